// File: rtl/map_sst_engine.sv
// map_sst_engine: save-state initiator for a single attached mapper core.
// DUMP reads SST_LEN bytes from the mapper and streams them out on a
// valid/ready byte port; LOAD accepts SST_LEN bytes from a valid/ready port
// and writes each one to the mapper with its own sst_we strobe.
// Optional feature macro: SST_IDX_CHECK_EN compares the mapper index byte
// (address SST_LEN-1) against exp_idx and flags a mismatch on err.
`timescale 1ns/1ps
module map_sst_engine #(
    parameter int SST_LEN  = 128,  // bytes per transfer, 2..256
    parameter int RD_WAIT  = 1,    // cycles from address change to sst_di sample, 1..7
    parameter int WE_WIDTH = 1     // sst_we pulse width in cycles, 1..7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_dump,
    input  logic       cmd_load,
    input  logic [7:0] exp_idx,
    output logic       sst_act,
    output logic [7:0] sst_addr,
    output logic       sst_we,
    output logic [7:0] sst_do,
    input  logic [7:0] sst_di,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] LAST_CNT = 8'(SST_LEN - 1);
    localparam logic [2:0] RD_SMP_T = 3'(RD_WAIT - 1);
    localparam logic [2:0] WE_END_T = 3'(WE_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_RD_OUT,
        ST_WR_IN,
        ST_WR_STB,
        ST_FIN
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] tmr_q, tmr_d;
    logic [7:0] sst_addr_q, sst_addr_d;
    logic [7:0] sst_do_q, sst_do_d;
    logic [7:0] out_data_q, out_data_d;

    logic is_last;
    logic rd_sample;
    logic wr_accept;
    logic start_xfer;

    assign is_last    = (cnt_q == LAST_CNT);
    assign rd_sample  = (state_q == ST_RD_WAIT) && (tmr_q == RD_SMP_T);
    assign wr_accept  = (state_q == ST_WR_IN) && in_valid;
    assign start_xfer = (state_q == ST_IDLE) && (cmd_dump || cmd_load);

    // Next-state logic: sequences address/wait/output for DUMP and accept/strobe for LOAD.
    always_comb begin
        // NOTE: every next-state variable is given its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        sst_addr_d = sst_addr_q;
        sst_do_d   = sst_do_q;
        out_data_d = out_data_q;

        case (state_q)
            ST_IDLE: begin
                // Dump has priority when both commands arrive together.
                if (cmd_dump) begin
                    state_d = ST_RD_ADDR;
                    cnt_d   = 8'd0;
                end else if (cmd_load) begin
                    state_d = ST_WR_IN;
                    cnt_d   = 8'd0;
                end
            end
            ST_RD_ADDR: begin
                sst_addr_d = cnt_q;
                tmr_d      = 3'd0;
                state_d    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (rd_sample) begin
                    out_data_d = sst_di;
                    state_d    = ST_RD_OUT;
                end else begin
                    tmr_d = tmr_q + 3'd1;
                end
            end
            ST_RD_OUT: begin
                // out_data_q is only rewritten in RD_WAIT, so it holds while stalled.
                if (out_ready) begin
                    if (is_last) begin
                        sst_addr_d = 8'd0;
                        state_d    = ST_FIN;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_WR_IN: begin
                if (wr_accept) begin
                    sst_do_d   = in_data;
                    sst_addr_d = cnt_q;
                    tmr_d      = 3'd0;
                    state_d    = ST_WR_STB;
                end
            end
            ST_WR_STB: begin
                // tmr 0 is the address/data setup cycle; tmr 1..WE_WIDTH drive the strobe.
                if (tmr_q == WE_END_T) begin
                    if (is_last) begin
                        sst_addr_d = 8'd0;
                        state_d    = ST_FIN;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = ST_WR_IN;
                    end
                end else begin
                    tmr_d = tmr_q + 3'd1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset aborts any transfer to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            tmr_q      <= 3'd0;
            sst_addr_q <= 8'd0;
            sst_do_q   <= 8'd0;
            out_data_q <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            sst_addr_q <= sst_addr_d;
            sst_do_q   <= sst_do_d;
            out_data_q <= out_data_d;
        end
    end

    // Status and handshake outputs decode directly from the registered state,
    // so an async reset drops sst_we, busy and in_ready immediately.
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign sst_act   = busy;
    assign done      = (state_q == ST_FIN);
    assign out_valid = (state_q == ST_RD_OUT);
    assign in_ready  = (state_q == ST_WR_IN);
    assign sst_we    = (state_q == ST_WR_STB) && (tmr_q != 3'd0);
    assign sst_addr  = sst_addr_q;
    assign sst_do    = sst_do_q;
    assign out_data  = out_data_q;

`ifdef SST_IDX_CHECK_EN
    logic mism_q, mism_d;
    logic err_q, err_d;

    // Capture an index-byte mismatch during the transfer and publish it on entry to FIN.
    always_comb begin
        mism_d = mism_q;
        err_d  = err_q;
        if (start_xfer) begin
            mism_d = 1'b0;
            err_d  = 1'b0;
        end else if (is_last && rd_sample) begin
            mism_d = (sst_di != exp_idx);
        end else if (is_last && wr_accept) begin
            mism_d = (in_data != exp_idx);
        end
        if ((state_d == ST_FIN) && (state_q != ST_FIN)) begin
            err_d = err_q | mism_q;
        end
    end

    // Index-check registers; err stays set until the next accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mism_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            mism_q <= mism_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_idx;
    assign unused_idx = ^{exp_idx, start_xfer};
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_map_sst_engine.sv
// tb_map_sst_engine: scoreboard bench for map_sst_engine.
// Stimulus pushes expected DUMP bytes / LOAD writes into queues; a monitor
// samples on the falling edge and pops/compares whenever the DUT presents a
// byte handshake or starts a write strobe.
`timescale 1ns/1ps
module tb_map_sst_engine;

    localparam int SST_LEN  = 128;
    localparam int RD_WAIT  = 1;
    localparam int WE_WIDTH = 1;
    localparam int DUMP_CYC = SST_LEN * (RD_WAIT + 2) + 1;
`ifdef SST_IDX_CHECK_EN
    localparam logic ERR_ON_MISMATCH = 1'b1;
`else
    localparam logic ERR_ON_MISMATCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_dump, cmd_load;
    logic [7:0] exp_idx;
    logic       sst_act, sst_we;
    logic [7:0] sst_addr, sst_do, sst_di;
    logic [7:0] out_data;
    logic       out_valid, out_ready;
    logic [7:0] in_data;
    logic       in_valid, in_ready;
    logic       busy, done, err;

    map_sst_engine #(
        .SST_LEN (SST_LEN),
        .RD_WAIT (RD_WAIT),
        .WE_WIDTH(WE_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_dump (cmd_dump),
        .cmd_load (cmd_load),
        .exp_idx  (exp_idx),
        .sst_act  (sst_act),
        .sst_addr (sst_addr),
        .sst_we   (sst_we),
        .sst_do   (sst_do),
        .sst_di   (sst_di),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Mapper model: readback is a combinational function of the address.
    logic [7:0] mapper_mem [256];
    always_comb sst_di = mapper_mem[sst_addr];

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int we_pulses = 0;
    int mode = 0;           // 0 none, 1 dump, 2 load
    bit rnd_ready = 1'b0;

    logic [7:0]  exp_rd [$];
    logic [15:0] exp_wr [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // out_ready driver: high, or a coin flip per cycle when backpressure is on.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    logic       we_prev = 1'b0;
    int         we_len = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev = 8'd0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                we_prev    = 1'b0;
                we_len     = 0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("rd_hold_valid", 32'(out_valid), 32'd1);
                    check("rd_hold_data", 32'(out_data), 32'(data_prev));
                end
                if (out_valid && out_ready) begin
                    if (exp_rd.size() == 0) fail_now("rd_unexpected_byte");
                    else check("rd_byte", 32'(out_data), 32'(exp_rd.pop_front()));
                end
                stall_prev = out_valid && !out_ready;
                data_prev  = out_data;

                if (sst_we && !we_prev) begin
                    we_pulses++;
                    if (exp_wr.size() == 0) fail_now("wr_unexpected_strobe");
                    else check("wr_addr_data", 32'({sst_addr, sst_do}), 32'(exp_wr.pop_front()));
                    we_len = 0;
                end
                if (sst_we) we_len++;
                else if (we_prev) check("we_width", 32'(we_len), 32'(WE_WIDTH));
                we_prev = sst_we;

                if (done) done_cnt++;
                if (mode == 1) check("no_we_in_dump", 32'(sst_we), 32'd0);
                if (mode == 2) check("no_valid_in_load", 32'(out_valid), 32'd0);
            end
        end
    end

    // Start a transfer and wait (bounded) for done; n counts clock edges from the
    // edge that samples the command up to the one that raises done.
    task automatic run_xfer(input logic d, input logic l, input int budget, output int n);
        @(posedge clk);
        #1 cmd_dump = d;
        cmd_load = l;
        @(posedge clk);
        #1 cmd_dump = 1'b0;
        cmd_load = 1'b0;
        n = 1;
        while (!done && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        if (!done) fail_now("done_timeout");
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit hs;
        int t;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        exp_wr.push_back({b, b});
        in_valid = 1'b1;
        in_data  = b;
        hs = 1'b0;
        t  = 0;
        while (!hs && t < 200) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1 t++;
        end
        if (!hs) fail_now("in_ready_timeout");
        in_valid = 1'b0;
    endtask

    task automatic push_dump(input logic [7:0] last_byte);
        for (int i = 0; i < SST_LEN - 1; i++) exp_rd.push_back(8'(255 - i));
        exp_rd.push_back(last_byte);
    endtask

    task automatic post_xfer(input string tag, input int done_base);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_act_idle"}, 32'(sst_act), 32'd0);
        check({tag, "_addr_zero"}, 32'(sst_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_done_count"}, 32'(done_cnt - done_base), 32'd1);
        check({tag, "_rd_queue_empty"}, 32'(exp_rd.size()), 32'd0);
        check({tag, "_wr_queue_empty"}, 32'(exp_wr.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int pulses_base;
        cmd_dump = 1'b0;
        cmd_load = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        exp_idx  = 8'h80;
        for (int a = 0; a < 256; a++) mapper_mem[a] = ~8'(a);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_sst_act", 32'(sst_act), 32'd0);
        check("rst_sst_addr", 32'(sst_addr), 32'd0);
        check("rst_sst_we", 32'(sst_we), 32'd0);
        check("rst_sst_do", 32'(sst_do), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);

        // Async reset in the middle of a LOAD, during the cnt=5 strobe.
        mode = 2;
        @(posedge clk);
        #1 cmd_load = 1'b1;
        @(posedge clk);
        #1 cmd_load = 1'b0;
        check("load_entry_busy", 32'(busy), 32'd1);
        check("load_entry_act", 32'(sst_act), 32'd1);
        check("load_entry_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) send_byte(8'(i), i % 3);
        n = 0;
        while (!sst_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_load_we_seen", 32'(sst_we), 32'd1);
        base = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("abort_sst_we", 32'(sst_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - base), 32'd0);
        check("abort_wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        mode = 0;

        // Nominal DUMP with out_ready high: FF..80 in order, fixed latency.
        mode = 1;
        push_dump(8'h80);
        base = done_cnt;
        run_xfer(1'b1, 1'b0, 2000, n);
        check("dump_latency", 32'(n), 32'(DUMP_CYC));
        check("dump_err_match", 32'(err), 32'd0);
        post_xfer("dump", base);

        // DUMP under random backpressure, with a stray cmd_load mid-transfer.
        rnd_ready = 1'b1;
        push_dump(8'h80);
        base = done_cnt;
        fork
            run_xfer(1'b1, 1'b0, 5000, n);
            begin
                repeat (40) @(posedge clk);
                #1 cmd_load = 1'b1;
                @(posedge clk);
                #1 cmd_load = 1'b0;
            end
        join
        rnd_ready = 1'b0;
        post_xfer("dump_bp", base);
        check("dump_bp_in_ready_idle", 32'(in_ready), 32'd0);

        // cmd_dump and cmd_load together: dump wins.
        push_dump(8'h80);
        base = done_cnt;
        run_xfer(1'b1, 1'b1, 2000, n);
        check("both_cmd_latency", 32'(n), 32'(DUMP_CYC));
        post_xfer("both_cmd", base);

        // LOAD 00..7F with gaps; addr == data on every strobe.
        mode = 2;
        exp_idx = 8'h7F;
        base = done_cnt;
        pulses_base = we_pulses;
        fork
            run_xfer(1'b0, 1'b1, 5000, n);
            for (int i = 0; i < SST_LEN; i++) send_byte(8'(i), i % 3);
        join
        check("load_err_match", 32'(err), 32'd0);
        post_xfer("load", base);
        check("load_pulse_count", 32'(we_pulses - pulses_base), 32'(SST_LEN));

        // Index byte mismatch: mapper byte 127 = 56, expected 55.
        mode = 1;
        mapper_mem[SST_LEN - 1] = 8'h56;
        exp_idx = 8'h55;
        push_dump(8'h56);
        base = done_cnt;
        run_xfer(1'b1, 1'b0, 2000, n);
        check("idx_err_at_fin", 32'(err), 32'(ERR_ON_MISMATCH));
        post_xfer("idx", base);
        check("idx_err_sticky", 32'(err), 32'(ERR_ON_MISMATCH));

        // Next dump with a matching index clears err on entry.
        mapper_mem[SST_LEN - 1] = 8'h80;
        exp_idx = 8'h80;
        push_dump(8'h80);
        base = done_cnt;
        fork
            run_xfer(1'b1, 1'b0, 2000, n);
            begin
                repeat (4) @(posedge clk);
                #1;
                check("err_cleared_busy", 32'(busy), 32'd1);
                check("err_cleared", 32'(err), 32'd0);
            end
        join
        check("err_clean_fin", 32'(err), 32'd0);
        post_xfer("clean", base);
        mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
